// File: rtl/uart_pkg.sv
// Shared UART types: parity mode, receiver FSM states and the parity check helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRKWAIT
  } rx_state_t;

  function automatic logic parity_err(input logic data_xor, input logic par_bit,
                                      input parity_t mode);
    return (data_xor ^ par_bit) != (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bit synchroniser with a selectable reset value (idle-high lines reset to 1).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_d,
  output logic out_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= in_d;
      r_sync <= r_meta;
    end
  end

  assign out_q = r_sync;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, parity/framing/break detection and a
// one-word valid/ready holding register that reports overrun when a frame must be dropped.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 242,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_rx,
  input  logic                 in_rx_ready,
  output logic                 out_rx_valid,
  output logic [DATA_BITS-1:0] out_rx_data,
  output logic                 out_parity_err,
  output logic                 out_frame_err,
  output logic                 out_overrun,
  output logic                 out_break,
  output logic                 out_busy
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam parity_t           PAR_CFG   = parity_t'(PARITY[1:0]);
  localparam logic              PAR_EN    = (PAR_CFG != PAR_NONE);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  logic                 w_rx_s;
  logic                 w_sample;
  logic                 w_last_stop;
  logic                 w_stop0;
  logic                 w_brk;
  logic                 w_deliver;
  logic                 w_frame_err;
  logic                 w_hs;

  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_par_bit;
  logic                 r_ferr;
  logic                 r_stop0;
  logic                 r_break;

  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_hold_perr;
  logic                 r_hold_ferr;
  logic                 r_overrun;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .in_d   (in_rx),
    .out_q  (w_rx_s)
  );

  assign w_sample    = (r_cnt == CNT_LAST);
  assign w_last_stop = (r_state == STOP) && w_sample && (r_stop_cnt == STOP_LAST);
  // With one stop bit the first stop bit is the one being sampled right now.
  assign w_stop0     = (r_stop_cnt == 1'b0) ? w_rx_s : r_stop0;
  assign w_brk       = (r_shift == '0) && !(PAR_EN && r_par_bit) && !w_stop0;
  assign w_deliver   = w_last_stop && !w_brk;
  assign w_frame_err = r_ferr | !w_rx_s;
  assign w_hs        = r_valid && in_rx_ready;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_par_bit  <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop0    <= 1'b0;
      r_break    <= 1'b0;
    end else begin
      r_break <= 1'b0;
      r_cnt   <= w_sample ? '0 : r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state    <= START;
            r_cnt      <= CNT_HALF;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_perr     <= 1'b0;
            r_par_bit  <= 1'b0;
            r_ferr     <= 1'b0;
          end
        end
        START: begin
          if (w_sample) r_state <= w_rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (w_sample) begin
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == BIT_LAST) r_state <= PAR_EN ? uart_pkg::PARITY : STOP;
            else                       r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        uart_pkg::PARITY: begin
          if (w_sample) begin
            r_perr    <= parity_err(^r_shift, w_rx_s, PAR_CFG);
            r_par_bit <= w_rx_s;
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_sample) begin
            r_ferr  <= w_frame_err;
            r_stop0 <= w_stop0;
            if (w_last_stop) begin
              r_break <= w_brk;
              r_state <= w_brk ? BRKWAIT : IDLE;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        BRKWAIT: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A frame completing while a handshake drains the holder takes its place directly.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_hold_perr <= 1'b0;
      r_hold_ferr <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_deliver && (!r_valid || w_hs)) begin
        r_valid     <= 1'b1;
        r_data      <= r_shift;
        r_hold_perr <= PAR_EN & r_perr;
        r_hold_ferr <= w_frame_err;
      end else if (w_hs) begin
        r_valid     <= 1'b0;
        r_data      <= '0;
        r_hold_perr <= 1'b0;
        r_hold_ferr <= 1'b0;
      end
      if (w_deliver && r_valid && !in_rx_ready) r_overrun <= 1'b1;
      else if (w_hs)                            r_overrun <= 1'b0;
    end
  end

  assign out_rx_valid   = r_valid;
  assign out_rx_data    = r_data;
  assign out_parity_err = r_hold_perr;
  assign out_frame_err  = r_hold_ferr;
  assign out_overrun    = r_overrun;
  assign out_break      = r_break;
  assign out_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench: an 8N1 receiver and an 8E1 receiver, both at 16 clocks per bit.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1, rdy0, rdy1;
  logic       v0, pe0, fe0, ov0, brk0, busy0;
  logic       v1, pe1, fe1, ov1, brk1, busy1;
  logic [7:0] d0, d1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vr0   = 0;
  int tv0   = 0;
  int bc0   = 0;
  logic v0_q = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .in_clk(clk), .in_rst(rst), .in_rx(rx0), .in_rx_ready(rdy0),
    .out_rx_valid(v0), .out_rx_data(d0), .out_parity_err(pe0), .out_frame_err(fe0),
    .out_overrun(ov0), .out_break(brk0), .out_busy(busy0)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .in_clk(clk), .in_rst(rst), .in_rx(rx1), .in_rx_ready(rdy1),
    .out_rx_valid(v1), .out_rx_data(d1), .out_parity_err(pe1), .out_frame_err(fe1),
    .out_overrun(ov1), .out_break(brk1), .out_busy(busy1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Count valid rises and break pulses of the 8N1 receiver, sampled mid-cycle.
  always @(negedge clk) begin
    v0_q <= v0;
    if (v0 && !v0_q) begin
      vr0 <= vr0 + 1;
      tv0 <= cyc;
    end
    if (brk0) bc0 <= bc0 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive bits LSB first, one bit period each; entered and left at posedge+1.
  task automatic tx_frame(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx0 = bits[i];
      else          rx1 = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rdy(input int sel);
    if (sel == 0) rdy0 = 1'b1; else rdy1 = 1'b1;
    @(posedge clk);
    #1;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
  endtask

  initial begin
    int t0;
    int lat;
    rst  = 1'b1;
    rx0  = 1'b1;
    rx1  = 1'b1;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_data", 32'(d0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_flags", 32'({pe0, fe0, ov0, brk0}), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // 8N1 0xA5: stop mid-point is 9.5 bits after the edge, plus sync and load.
    t0 = cyc;
    tx_frame(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
    lat = tv0 - t0;
    chk("a5_rises", 32'(vr0), 32'd1);
    chk("a5_latency_in_149_156", 32'(lat >= 149 && lat <= 156), 32'd1);
    chk("a5_valid", 32'(v0), 32'd1);
    chk("a5_data", 32'(d0), 32'hA5);
    chk("a5_flags", 32'({pe0, fe0, ov0}), 32'd0);
    pulse_rdy(0);
    chk("a5_consumed", 32'(v0), 32'd0);

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong; 0x03 with 0 is right.
    tx_frame(1, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
    chk("p07_valid", 32'(v1), 32'd1);
    chk("p07_data", 32'(d1), 32'h07);
    chk("p07_perr", 32'(pe1), 32'd1);
    chk("p07_ferr", 32'(fe1), 32'd0);
    pulse_rdy(1);
    chk("p07_flag_clr", 32'({v1, pe1}), 32'd0);
    tx_frame(1, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11);
    chk("p03_data", 32'(d1), 32'h03);
    chk("p03_perr", 32'(pe1), 32'd0);
    pulse_rdy(1);

    // Stop bit driven low on non-zero data: framing error, not a break.
    tx_frame(0, 16'({1'b0, 8'h3C, 1'b0}), 10);
    rx0 = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    chk("3c_rises", 32'(vr0), 32'd2);
    chk("3c_data", 32'(d0), 32'h3C);
    chk("3c_ferr", 32'(fe0), 32'd1);
    chk("3c_perr", 32'(pe0), 32'd0);
    chk("3c_no_break", 32'(bc0), 32'd0);
    pulse_rdy(0);
    chk("3c_ferr_clr", 32'(fe0), 32'd0);

    // Start glitch of 5 clocks.
    rx0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("glitch_busy", 32'(busy0), 32'd1);
    rx0 = 1'b1;
    for (int i = 0; i < 10 && busy0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("glitch_idle", 32'(busy0), 32'd0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    chk("glitch_no_word", 32'({vr0[3:0], v0}), 32'({4'd2, 1'b0}));

    // Overrun: second frame dropped while holder is full and ready is low.
    tx_frame(0, 16'({1'b1, 8'h11, 1'b0}), 10);
    tx_frame(0, 16'({1'b1, 8'h22, 1'b0}), 10);
    repeat (CPB) @(posedge clk);
    #1;
    chk("ovr_data", 32'(d0), 32'h11);
    chk("ovr_flag", 32'(ov0), 32'd1);
    chk("ovr_valid", 32'(v0), 32'd1);
    pulse_rdy(0);
    chk("ovr_clr", 32'({v0, ov0}), 32'd0);

    // Line held low for 12 bit times: one break pulse, no word.
    rx0 = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    #1;
    chk("brk_busy_wait", 32'(busy0), 32'd1);
    rx0 = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    chk("brk_count", 32'(bc0), 32'd1);
    chk("brk_no_word", 32'({vr0[3:0], v0}), 32'({4'd3, 1'b0}));
    chk("brk_idle", 32'(busy0), 32'd0);

    // Fill holder with overrun, start a frame, then reset mid-frame.
    tx_frame(0, 16'({1'b1, 8'h5A, 1'b0}), 10);
    tx_frame(0, 16'({1'b1, 8'h6B, 1'b0}), 10);
    chk("pre_rst_state", 32'({v0, ov0, d0}), 32'({1'b1, 1'b1, 8'h5A}));
    rx0 = 1'b0;
    repeat (5 * CPB) @(posedge clk);
    #1;
    chk("mid_frame_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_outputs", 32'({v0, d0, pe0, fe0, ov0, brk0, busy0}), 32'd0);
    rst = 1'b0;
    rx0 = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    #1;
    chk("rst_no_delivery", 32'({vr0[3:0], v0, busy0}), 32'({4'd4, 2'b00}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
